exe_mem_skid: RTL and testbench
===============================

EXE_MEM_SKID -- requirements
Module: exe_mem_skid

Interface
REQ-001 Parameter STALL_CNT_W, default 16, width of the saturating stall counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 valid_i  input  1  upstream (execute) entry valid.
REQ-005 ready_o  output  1  block can accept an entry this cycle.
REQ-006 result_i  input  32  ALU result.
REQ-007 jump_now_i  input  1  ALU branch decision; may be X when is_branch_i=0.
REQ-008 is_branch_i  input  1  entry is a conditional branch.
REQ-009 rd_addr_i  input  5  destination register index.
REQ-010 wen_i  input  1  entry writes the register file.
REQ-011 is_mem_i  input  1  entry is a load or store.
REQ-012 store_data_i  input  32  store data.
REQ-013 flush_i  input  1  synchronous squash of all held entries.
REQ-014 valid_o, ready_i  output/input  1 each  downstream (memory stage) handshake.
REQ-015 result_o 32, jump_now_o 1, rd_addr_o 5, wen_o 1, is_mem_o 1, store_data_o 32  outputs  head entry fields.
REQ-016 fwd_valid_o 1, fwd_addr_o 5, fwd_data_o 32  outputs  forwarding to ALU operand muxes.
REQ-017 stall_cnt_o  output  STALL_CNT_W  cycles with valid_o=1 and ready_i=0.

Function
REQ-018 Two-entry skid buffer: head register (drives outputs) and skid register.
REQ-019 States EMPTY, ONE, FULL; valid_o=1 in ONE and FULL.
REQ-020 ready_o SHALL be 1 iff state!=FULL, driven from a register; no combinational path ready_i->ready_o or valid_i->valid_o.
REQ-021 Input fires on valid_i&ready_o; output fires on valid_o&ready_i.
REQ-022 EMPTY: input fire -> head loads, ONE; else stay.
REQ-023 ONE: in+out fire -> head reloads, ONE; in only -> skid loads, FULL; out only -> EMPTY.
REQ-024 FULL: out fire -> head<=skid, ONE; otherwise hold; valid_i ignored.
REQ-025 Latency: entry accepted in EMPTY appears on outputs the next cycle.
REQ-026 Order preserved; no entry dropped or duplicated except by flush_i/reset.
REQ-027 Stored jump bit SHALL be jump_now_i & is_branch_i, never X when is_branch_i=0.
REQ-028 flush_i=1 has priority over all fires: next state EMPTY, same-cycle input discarded, stall counter unchanged.
REQ-029 Output fields while valid_o=0 SHALL hold last value; consumers ignore them.
REQ-030 fwd_valid_o = valid_o & wen_o & (rd_addr_o!=0) & ~is_mem_o; fwd_addr_o=rd_addr_o; fwd_data_o=result_o; skid entry is never forwarded.
REQ-031 stall_cnt_o increments each cycle valid_o&~ready_i, saturates at all-ones, never wraps.

Reset
REQ-032 reset=1 SHALL immediately (without clk) force state EMPTY, ready_o=1 after deassertion, valid_o=0, all data outputs 0, fwd_valid_o=0, stall_cnt_o=0.
REQ-033 Reset mid-operation discards both entries; first clk after deassertion behaves as EMPTY.

Verification
REQ-034 Empty, valid_i=1 result_i=32'h0000_0005 rd_addr_i=3 wen_i=1, ready_i=1 -> next cycle valid_o=1 result_o=5, fwd_valid_o=1 fwd_addr_o=3.
REQ-035 ready_i=0, push A=1 then B=2 -> ready_o=0 after B; raise ready_i -> outputs A then B on consecutive cycles, ready_o=1 after A leaves.
REQ-036 FULL with flush_i=1 and valid_i=1 -> next cycle valid_o=0, ready_o=1, entry discarded.
REQ-037 is_branch_i=0, jump_now_i=X -> jump_now_o=0; is_branch_i=1 jump_now_i=1 -> jump_now_o=1.
REQ-038 STALL_CNT_W=4, hold valid_o=1 ready_i=0 for 20 cycles -> stall_cnt_o=4'hF; rd_addr_i=0 wen_i=1 -> fwd_valid_o=0.
REQ-039 Assert reset asynchronously while FULL -> valid_o=0, outputs 0 before next clk edge.

Source files
------------

// File: rtl/exe_mem_skid.sv
// Execute-to-memory pipeline register: a two-entry skid buffer with head forwarding and a stall counter.
// Latency: an entry accepted while empty appears on the outputs one cycle later.
// Backpressure: ready_o is a registered "not full" flag, so ready_i never reaches ready_o combinationally.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   valid_i/ready_o, *_i        upstream entry: result, branch decision, rd, wen, is_mem, store data
//   flush_i                     squash every held entry and any same-cycle input
//   valid_o/ready_i, *_o        downstream head entry fields
//   fwd_valid_o/addr/data       head-entry bypass to the ALU operand muxes
//   stall_cnt_o                 saturating count of cycles with valid_o=1 and ready_i=0
module exe_mem_skid #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [31:0]            result_i,
   input  logic                   jump_now_i,
   input  logic                   is_branch_i,
   input  logic [4:0]             rd_addr_i,
   input  logic                   wen_i,
   input  logic                   is_mem_i,
   input  logic [31:0]            store_data_i,
   input  logic                   flush_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [31:0]            result_o,
   output logic                   jump_now_o,
   output logic [4:0]             rd_addr_o,
   output logic                   wen_o,
   output logic                   is_mem_o,
   output logic [31:0]            store_data_o,
   output logic                   fwd_valid_o,
   output logic [4:0]             fwd_addr_o,
   output logic [31:0]            fwd_data_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [31:0] result;
      logic        jump;
      logic [4:0]  rd_addr;
      logic        wen;
      logic        is_mem;
      logic [31:0] store_data;
   } entry_t;

   state_t                 state_q, state_d;
   entry_t                 head_q, head_d;
   entry_t                 skid_q, skid_d;
   entry_t                 in_entry;
   logic                   ready_q, ready_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic                   in_fire, out_fire;

   // The jump bit is qualified by is_branch_i so a don't-care ALU decision
   // on non-branch entries can never leak into the stored entry.
   always_comb begin
      in_entry            = '0;
      in_entry.result     = result_i;
      in_entry.jump       = jump_now_i & is_branch_i;
      in_entry.rd_addr    = rd_addr_i;
      in_entry.wen        = wen_i;
      in_entry.is_mem     = is_mem_i;
      in_entry.store_data = store_data_i;
   end

   assign valid_o  = (state_q != EMPTY);
   assign ready_o  = ready_q;
   assign in_fire  = valid_i & ready_q;
   assign out_fire = valid_o & ready_i;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush_i) begin
         // Flush wins over both fires; the head register keeps its stale
         // contents, which is harmless because valid_o drops.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  head_d  = in_entry;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  head_d = in_entry;
               end else if (in_fire) begin
                  skid_d  = in_entry;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  head_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      // Precomputing next-cycle readiness keeps ready_o a pure flop output.
      ready_d = (state_d != FULL);

      stall_d = stall_q;
      if (!flush_i && valid_o && !ready_i && (stall_q != {STALL_CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
         stall_q <= stall_d;
      end
   end

   assign result_o     = head_q.result;
   assign jump_now_o   = head_q.jump;
   assign rd_addr_o    = head_q.rd_addr;
   assign wen_o        = head_q.wen;
   assign is_mem_o     = head_q.is_mem;
   assign store_data_o = head_q.store_data;

   // Only the head is forwarded: a load's data is not known yet, and x0 is hardwired zero.
   assign fwd_valid_o  = valid_o & head_q.wen & (head_q.rd_addr != 5'd0) & ~head_q.is_mem;
   assign fwd_addr_o   = head_q.rd_addr;
   assign fwd_data_o   = head_q.result;
   assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_exe_mem_skid.sv
module tb_exe_mem_skid;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_i, ready_o;
   logic [31:0]   result_i;
   logic          jump_now_i, is_branch_i;
   logic [4:0]    rd_addr_i;
   logic          wen_i, is_mem_i;
   logic [31:0]   store_data_i;
   logic          flush_i;
   logic          valid_o, ready_i;
   logic [31:0]   result_o;
   logic          jump_now_o;
   logic [4:0]    rd_addr_o;
   logic          wen_o, is_mem_o;
   logic [31:0]   store_data_o;
   logic          fwd_valid_o;
   logic [4:0]    fwd_addr_o;
   logic [31:0]   fwd_data_o;
   logic [W-1:0]  stall_cnt_o;

   always #5 clk = ~clk;

   exe_mem_skid #(.STALL_CNT_W(W)) dut (
      .clk(clk), .reset(reset),
      .valid_i(valid_i), .ready_o(ready_o),
      .result_i(result_i), .jump_now_i(jump_now_i), .is_branch_i(is_branch_i),
      .rd_addr_i(rd_addr_i), .wen_i(wen_i), .is_mem_i(is_mem_i),
      .store_data_i(store_data_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .jump_now_o(jump_now_o), .rd_addr_o(rd_addr_o),
      .wen_o(wen_o), .is_mem_o(is_mem_o), .store_data_o(store_data_o),
      .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
      .stall_cnt_o(stall_cnt_o)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i = 0; ready_i = 1; flush_i = 0; result_i = 0; jump_now_i = 0;
      is_branch_i = 0; rd_addr_i = 0; wen_i = 0; is_mem_i = 0; store_data_i = 0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        v, rdy, fl;
      logic [31:0] res;
      logic [4:0]  rd;
      logic        wen, mem, br, jn;
      logic        e_vld, e_rdy;
      logic [31:0] e_res;
      logic        e_fwd, e_jmp;
      logic [3:0]  e_stall;
   } row_t;

   row_t tbl[15];

   function automatic row_t mk(logic v, logic rdy, logic fl, logic [31:0] res, logic [4:0] rd,
                               logic wen, logic mem, logic br, logic jn,
                               logic e_vld, logic e_rdy, logic [31:0] e_res,
                               logic e_fwd, logic e_jmp, logic [3:0] e_stall);
      row_t r;
      r.v = v; r.rdy = rdy; r.fl = fl; r.res = res; r.rd = rd; r.wen = wen; r.mem = mem;
      r.br = br; r.jn = jn; r.e_vld = e_vld; r.e_rdy = e_rdy; r.e_res = e_res;
      r.e_fwd = e_fwd; r.e_jmp = e_jmp; r.e_stall = e_stall;
      return r;
   endfunction

   // ---------------- behavioural reference ----------------
   typedef struct packed {
      logic [31:0] result;
      logic        jump;
      logic [4:0]  rd;
      logic        wen, mem;
      logic [31:0] sd;
   } ment_t;

   ment_t mq[$];
   ment_t mhead;
   int    mcnt;

   task automatic model_reset();
      mq.delete();
      mhead = '0;
      mcnt  = 0;
   endtask

   // Applies one clock edge worth of rules to the model using the current inputs.
   task automatic model_step();
      ment_t e;
      bit    o, in;
      if (!flush_i && mq.size() > 0 && !ready_i && mcnt < (1 << W) - 1) mcnt++;
      if (flush_i) begin
         mq.delete();
      end else begin
         o  = (mq.size() > 0) && ready_i;
         in = valid_i && (mq.size() < 2);
         if (o) void'(mq.pop_front());
         if (in) begin
            e.result = result_i; e.jump = jump_now_i && is_branch_i; e.rd = rd_addr_i;
            e.wen = wen_i; e.mem = is_mem_i; e.sd = store_data_i;
            mq.push_back(e);
         end
      end
      if (mq.size() > 0) mhead = mq[0];
   endtask

   task automatic model_check();
      logic mv, fv;
      mv = (mq.size() > 0);
      fv = mv && mhead.wen && (mhead.rd != 0) && !mhead.mem;
      chk("rnd_valid", valid_o, mv);
      chk("rnd_ready", ready_o, mq.size() < 2);
      chk("rnd_result", result_o, mhead.result);
      chk("rnd_jump", jump_now_o, mhead.jump);
      chk("rnd_rd", rd_addr_o, mhead.rd);
      chk("rnd_wen", wen_o, mhead.wen);
      chk("rnd_mem", is_mem_o, mhead.mem);
      chk("rnd_sd", store_data_o, mhead.sd);
      chk("rnd_fwd_valid", fwd_valid_o, fv);
      chk("rnd_fwd_addr", fwd_addr_o, mhead.rd);
      chk("rnd_fwd_data", fwd_data_o, mhead.result);
      chk("rnd_stall", stall_cnt_o, mcnt);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #3;
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_result", result_o, 32'h0);
      chk("rst_fwd", fwd_valid_o, 1'b0);
      chk("rst_stall", stall_cnt_o, 4'h0);
      #9 reset = 1'b0;      // released away from any edge
      #1;
      chk("rst_ready", ready_o, 1'b1);

      //              v rdy fl res     rd wen mem br jn | vld rdy res   fwd jmp st
      tbl[0]  = mk(1, 1, 0, 32'h5,  3, 1, 0, 0, 0,  1, 1, 32'h5,  1, 0, 0);
      tbl[1]  = mk(0, 1, 0, 32'h0,  0, 0, 0, 0, 0,  0, 1, 32'h5,  0, 0, 0);
      tbl[2]  = mk(1, 0, 0, 32'h1,  1, 1, 0, 0, 0,  1, 1, 32'h1,  1, 0, 0);
      tbl[3]  = mk(1, 0, 0, 32'h2,  2, 1, 0, 0, 0,  1, 0, 32'h1,  1, 0, 1);
      tbl[4]  = mk(1, 1, 0, 32'h9,  9, 1, 0, 0, 0,  1, 1, 32'h2,  1, 0, 1);
      tbl[5]  = mk(0, 1, 0, 32'h0,  0, 0, 0, 0, 0,  0, 1, 32'h2,  0, 0, 1);
      tbl[6]  = mk(1, 0, 0, 32'h7,  7, 1, 0, 0, 0,  1, 1, 32'h7,  1, 0, 1);
      tbl[7]  = mk(1, 0, 0, 32'h8,  8, 1, 0, 0, 0,  1, 0, 32'h7,  1, 0, 2);
      tbl[8]  = mk(1, 0, 1, 32'h9,  9, 1, 0, 0, 0,  0, 1, 32'h7,  0, 0, 2);
      tbl[9]  = mk(0, 1, 0, 32'h0,  0, 0, 0, 0, 0,  0, 1, 32'h7,  0, 0, 2);
      tbl[10] = mk(1, 1, 0, 32'h10, 4, 0, 0, 0, 1,  1, 1, 32'h10, 0, 0, 2);
      tbl[11] = mk(1, 1, 0, 32'h11, 5, 1, 0, 1, 1,  1, 1, 32'h11, 1, 1, 2);
      tbl[12] = mk(1, 1, 0, 32'h12, 0, 1, 0, 0, 0,  1, 1, 32'h12, 0, 0, 2);
      tbl[13] = mk(1, 1, 0, 32'h13, 6, 1, 1, 0, 0,  1, 1, 32'h13, 0, 0, 2);
      tbl[14] = mk(0, 1, 0, 32'h0,  0, 0, 0, 0, 0,  0, 1, 32'h13, 0, 0, 2);

      for (int i = 0; i < 15; i++) begin
         valid_i = tbl[i].v; ready_i = tbl[i].rdy; flush_i = tbl[i].fl;
         result_i = tbl[i].res; rd_addr_i = tbl[i].rd; wen_i = tbl[i].wen;
         is_mem_i = tbl[i].mem; is_branch_i = tbl[i].br; jump_now_i = tbl[i].jn;
         store_data_i = ~tbl[i].res;
         tick();
         chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].e_vld);
         chk($sformatf("tbl%0d_ready", i), ready_o, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_result", i), result_o, tbl[i].e_res);
         chk($sformatf("tbl%0d_fwd", i), fwd_valid_o, tbl[i].e_fwd);
         chk($sformatf("tbl%0d_jump", i), jump_now_o, tbl[i].e_jmp);
         chk($sformatf("tbl%0d_stall", i), stall_cnt_o, tbl[i].e_stall);
      end
      chk("tbl_fwd_addr", fwd_addr_o, 5'd6);
      chk("tbl_store_data", store_data_o, ~32'h13);

      // Stall counter saturation: hold one entry against backpressure.
      idle();
      valid_i = 1; ready_i = 0; result_i = 32'hAB; rd_addr_i = 7; wen_i = 1;
      tick();
      valid_i = 0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall", stall_cnt_o, 4'hF);
      chk("sat_valid", valid_o, 1'b1);
      chk("sat_result", result_o, 32'hAB);

      // Asynchronous reset while FULL.
      valid_i = 1; result_i = 32'hCD; rd_addr_i = 8;
      tick();
      chk("full_ready", ready_o, 1'b0);
      #1 reset = 1'b1;
      #1;
      chk("arst_valid", valid_o, 1'b0);
      chk("arst_result", result_o, 32'h0);
      chk("arst_rd", rd_addr_o, 5'd0);
      chk("arst_fwd", fwd_valid_o, 1'b0);
      chk("arst_stall", stall_cnt_o, 4'h0);
      #2 reset = 1'b0;
      #1;
      chk("arst_ready", ready_o, 1'b1);
      idle();
      valid_i = 1; result_i = 32'h33; rd_addr_i = 9; wen_i = 1;
      tick();
      chk("post_rst_valid", valid_o, 1'b1);
      chk("post_rst_result", result_o, 32'h33);
      valid_i = 0;
      tick();
      chk("post_rst_drain", valid_o, 1'b0);

      // Randomized run against the queue model.
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      model_reset();
      for (int i = 0; i < 600; i++) begin
         valid_i      = ($urandom_range(0, 3) != 0);
         ready_i      = ($urandom_range(0, 2) != 0) || (i > 300 && i < 330 ? 1'b0 : 1'b0);
         if (i >= 300 && i < 330) ready_i = 0;
         flush_i      = ($urandom_range(0, 24) == 0);
         result_i     = $urandom;
         store_data_i = $urandom;
         rd_addr_i    = 5'($urandom_range(0, 31));
         wen_i        = $urandom_range(0, 1);
         is_mem_i     = ($urandom_range(0, 3) == 0);
         is_branch_i  = $urandom_range(0, 1);
         jump_now_i   = $urandom_range(0, 1);
         model_step();
         tick();
         model_check();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
